// File: rtl/ctrl_pkg.sv
// Shared decode-stage definitions: opcode and funct7 constants, control field
// widths and the packed control bundle written into the stage FIFO.
package ctrl_pkg;

    localparam int unsigned OP_W        = 7;
    localparam int unsigned IMMSRC_W    = 3;
    localparam int unsigned ALUOP_W     = 2;
    localparam int unsigned RESULTSRC_W = 2;
    localparam int unsigned CTRL_W      = 12;

    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

    localparam logic [OP_W-1:0] F7_BASE   = 7'b0000000;
    localparam logic [OP_W-1:0] F7_ALT    = 7'b0100000;
    localparam logic [OP_W-1:0] F7_MULDIV = 7'b0000001;

    // Field order (MSB first) matches the decode table so rows can be cast
    // straight from a 12-bit literal.
    typedef struct packed {
        logic                   regwrite;
        logic [IMMSRC_W-1:0]    immsrc;
        logic                   alusrc;
        logic                   memwrite;
        logic [RESULTSRC_W-1:0] resultsrc;
        logic                   branch;
        logic [ALUOP_W-1:0]     aluop;
        logic                   jump;
    } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational opcode/funct7 decoder producing the control bundle.
// Ports: op_i, funct7_i -> ctrl_o (bundle), mext_o, illegal_o.
// Macro RV32M_EN: when defined, R-type with funct7=0000001 decodes as a
// multiply/divide op (mext_o=1); otherwise that encoding is illegal and
// mext_o is constant 0.
module ctrl_decode_comb
    import ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    input  logic [OP_W-1:0] funct7_i,
    output ctrl_bundle_t    ctrl_o,
    output logic            mext_o,
    output logic            illegal_o
);

    // Unknown encodings fall through to an all-zero bundle with illegal set.
    always_comb begin
        ctrl_o    = '0;
        mext_o    = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                if (funct7_i == F7_BASE || funct7_i == F7_ALT) begin
                    ctrl_o = ctrl_bundle_t'(12'b1_000_0_0_00_0_10_0);
                end
`ifdef RV32M_EN
                else if (funct7_i == F7_MULDIV) begin
                    ctrl_o = ctrl_bundle_t'(12'b1_000_0_0_00_0_10_0);
                    mext_o = 1'b1;
                end
`endif
                else begin
                    illegal_o = 1'b1;
                end
            end
            OP_ITYPE:  ctrl_o = ctrl_bundle_t'(12'b1_000_1_0_00_0_10_0);
            OP_BRANCH: ctrl_o = ctrl_bundle_t'(12'b0_010_0_0_00_1_01_0);
            OP_LOAD:   ctrl_o = ctrl_bundle_t'(12'b1_000_1_0_01_0_00_0);
            OP_STORE:  ctrl_o = ctrl_bundle_t'(12'b0_001_1_1_00_0_00_0);
            OP_LUI:    ctrl_o = ctrl_bundle_t'(12'b1_100_1_0_11_0_00_0);
            OP_AUIPC:  ctrl_o = ctrl_bundle_t'(12'b1_100_0_0_11_0_00_0);
            OP_JALR:   ctrl_o = ctrl_bundle_t'(12'b1_000_1_0_10_0_11_1);
            OP_JAL:    ctrl_o = ctrl_bundle_t'(12'b1_011_1_0_10_0_00_1);
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Decode stage: decodes op/funct7 into a control bundle and buffers it with
// its sideband tag in a DEPTH-entry FIFO (1-cycle latency, valid/ready).
// Ports: clk, rst_n (async, active-low); in_valid/in_ready, op, funct7, tag
// (input side); flush (drop all entries, wins over push/pop); out_valid/
// out_ready (output side); regwrite, immsrc, alusrc, memwrite, resultsrc,
// branch, aluop, jump, mext, illegal, tag_out (head entry, zero when empty);
// count (occupancy).
// Macro RV32M_EN: enables multiply/divide decode (see ctrl_decode_comb).
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        op,
    input  logic [OP_W-1:0]        funct7,
    input  logic [TAG_W-1:0]       tag,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   regwrite,
    output logic                   alusrc,
    output logic                   memwrite,
    output logic                   branch,
    output logic                   jump,
    output logic [IMMSRC_W-1:0]    immsrc,
    output logic [ALUOP_W-1:0]     aluop,
    output logic [RESULTSRC_W-1:0] resultsrc,
    output logic                   mext,
    output logic                   illegal,
    output logic [TAG_W-1:0]       tag_out,
    output logic [2:0]             count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 3;

    ctrl_bundle_t     dec_ctrl;
    logic             dec_mext;
    logic             dec_illegal;

    ctrl_bundle_t     ctrl_q    [DEPTH];
    logic             mext_q    [DEPTH];
    logic             illegal_q [DEPTH];
    logic [TAG_W-1:0] tag_q     [DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic             push;
    logic             pop;
    ctrl_bundle_t     head_ctrl_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    ctrl_decode_comb u_dec (
        .op_i      (op),
        .funct7_i  (funct7),
        .ctrl_o    (dec_ctrl),
        .mext_o    (dec_mext),
        .illegal_o (dec_illegal)
    );

    // Handshake: a full buffer still accepts when its head leaves this cycle.
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready && !flush;
    assign in_ready  = rst_n && !flush && ((count_q < CNT_W'(DEPTH)) || pop);
    assign push      = in_valid && in_ready;

    // Occupancy and pointer next-state.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // State and entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i]    <= '0;
                mext_q[i]    <= 1'b0;
                illegal_q[i] <= 1'b0;
                tag_q[i]     <= '0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) begin
                ctrl_q[wr_ptr_q]    <= dec_ctrl;
                mext_q[wr_ptr_q]    <= dec_mext;
                illegal_q[wr_ptr_q] <= dec_illegal;
                tag_q[wr_ptr_q]     <= tag;
            end
        end
    end

    // Head entry, zeroed while the buffer is empty.
    assign head_ctrl_c = out_valid ? ctrl_q[rd_ptr_q] : '0;

    assign regwrite  = head_ctrl_c.regwrite;
    assign immsrc    = head_ctrl_c.immsrc;
    assign alusrc    = head_ctrl_c.alusrc;
    assign memwrite  = head_ctrl_c.memwrite;
    assign resultsrc = head_ctrl_c.resultsrc;
    assign branch    = head_ctrl_c.branch;
    assign aluop     = head_ctrl_c.aluop;
    assign jump      = head_ctrl_c.jump;
    assign mext      = out_valid && mext_q[rd_ptr_q];
    assign illegal   = out_valid && illegal_q[rd_ptr_q];
    assign tag_out   = out_valid ? tag_q[rd_ptr_q] : '0;
    assign count     = count_q;

endmodule

// File: doc/ctrl_decode_stage.md
CTRL_DECODE_STAGE -- requirements
Module: ctrl_decode_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning output buffer entries (legal 1..4).
REQ-002 SHALL have parameter TAG_W, default 5, meaning width of the sideband tag carried with each instruction.
REQ-003 SHALL have these ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage can accept.
- op  in  7  opcode.
- funct7  in  7  funct7 field.
- tag  in  TAG_W  sideband tag.
- flush  in  1  discard all buffered entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- regwrite, alusrc, memwrite, branch, jump  out  1 each  control bits.
- immsrc  out  3  immediate select.
- aluop  out  2  ALU op class.
- resultsrc  out  2  result select.
- mext  out  1  multiply/divide op.
- illegal  out  1  opcode not decodable.
- tag_out  out  TAG_W  head tag.
- count  out  3  occupied entries.

Function
REQ-004 SHALL decode {regwrite,immsrc,alusrc,memwrite,resultsrc,branch,aluop,jump} as:
- 0110011: 1,000,0,0,00,0,10,0
- 0010011: 1,000,1,0,00,0,10,0
- 1100011: 0,010,0,0,00,1,01,0
- 0000011: 1,000,1,0,01,0,00,0
- 0100011: 0,001,1,1,00,0,00,0
- 0110111: 1,100,1,0,11,0,00,0
- 0010111: 1,100,0,0,11,0,00,0
- 1100111: 1,000,1,0,10,0,11,1
- 1101111: 1,011,1,0,10,0,00,1
REQ-005 SHALL, for any other opcode, write an entry with all control bits 0 and illegal=1; no X values are ever stored.
REQ-006 SHALL store the decoded bundle plus tag into a DEPTH-entry FIFO on an in_valid && in_ready cycle; the entry is visible at the outputs the next cycle, so latency is 1 cycle.
REQ-007 SHALL drive in_ready = (count < DEPTH) || (out_valid && out_ready), allowing a same-cycle push when full and popping.
REQ-008 SHALL pop the head on out_valid && out_ready; out_valid = (count != 0).
REQ-009 SHALL, on simultaneous push and pop, leave count unchanged and keep order (FIFO).
REQ-010 SHALL wrap read and write pointers modulo DEPTH.
REQ-011 SHALL hold all output fields stable while out_valid && !out_ready.
REQ-012 SHALL, on flush, set count to 0 and pointers to 0 at the next edge; flush has priority over push and pop in the same cycle, and in_ready is forced 0 during flush.
REQ-013 SHALL drive all control outputs, mext, illegal and tag_out to 0 when out_valid=0.

Reset
REQ-014 SHALL, while rst_n=0, asynchronously clear count, pointers, out_valid and all outputs to 0; in_ready=0 during reset and 1 in the first cycle after release.
REQ-015 SHALL discard buffered entries when reset is asserted mid-operation.

Configuration
REQ-016 SHALL use the macro RV32M_EN.
- Defined: op=0110011 with funct7=0000001 decodes as R-type with mext=1, aluop=10.
- Not defined: that encoding gives illegal=1, and mext is tied 0.
- R-type with funct7 other than 0000000, 0100000 or 0000001 is illegal in both builds.

Structure
REQ-017 SHALL place opcode constants, the field widths (immsrc 3, aluop 2, resultsrc 2) and the packed control-bundle width (12) in the shared package ctrl_pkg.
REQ-018 SHALL use one sub-module, ctrl_decode_comb: a pure combinational op/funct7 to bundle decoder instanced once; the FIFO stays in the top.

Verification
REQ-019 Reset: rst_n=0 mid-stream with count=2 -> out_valid=0 and count=0 immediately; in_ready=1 one cycle after release.
REQ-020 Decode sweep: push each of the 9 opcodes with out_ready=1 -> the REQ-004 bundle appears 1 cycle later with tag preserved; op=0001111 -> illegal=1, all controls 0.
REQ-021 Backpressure: DEPTH=2, out_ready=0, push 3 -> count=2, in_ready=0, third instruction held; raise out_ready with in_valid=1 -> push and pop in the same cycle, count stays 2, order kept.
REQ-022 Flush: count=2 plus in_valid, out_ready and flush all 1 -> next cycle count=0, out_valid=0, nothing pushed.
REQ-023 Config: op=0110011, funct7=0000001 -> mext=1, illegal=0 with RV32M_EN; illegal=1, mext=0 without it.
REQ-024 Wrap: DEPTH=3, 10 back-to-back push/pop with random out_ready -> tags exit in order, no loss or duplication.
